pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/ready pipeline stage register.
// Provides the stage state encoding and the flush pass-through mask builder.
package pipe_pkg;

    // Default geometry of a stage register (four 32-bit fields).
    localparam int unsigned DefWidth     = 32;
    localparam int unsigned DefNumFields = 4;
    localparam int unsigned DATA_W       = DefNumFields * DefWidth;

    // Upper bounds used to size the mask helper's fixed-width return value.
    localparam int unsigned MaxFields = 32;
    localparam int unsigned MaxDataW  = 1024;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StFull  = 2'b01,
        StSkid  = 2'b11
    } stage_state_e;

    // Expand a per-field select into a per-bit mask; field i occupies bits
    // [i*width +: width].
    function automatic logic [MaxDataW-1:0] bubble_mask(
        input int unsigned          width,
        input int unsigned          num_fields,
        input logic [MaxFields-1:0] pass_mask
    );
        logic [MaxDataW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < num_fields; i++) begin
            for (int unsigned b = 0; b < width; b++) begin
                if (pass_mask[i]) begin
                    m[i*width+b] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, a one-entry skid buffer
// that keeps in_ready registered, and flush-to-bubble with selectable pass fields.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned             WIDTH      = 32,
    parameter int unsigned             NUM_FIELDS = 4,
    parameter logic [NUM_FIELDS-1:0]   PASS_MASK  = 4'b0001,
    parameter int unsigned             CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_FIELDS*WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_FIELDS*WIDTH-1:0] out_data,
    input  logic                        flush,
    output logic [CNT_W-1:0]            bubble_cnt
);

    localparam int unsigned DataW = NUM_FIELDS * WIDTH;

    localparam logic [MaxFields-1:0] PassMaskExt = MaxFields'(PASS_MASK);
    localparam logic [MaxDataW-1:0]  FullMask    = bubble_mask(WIDTH, NUM_FIELDS, PassMaskExt);
    localparam logic [DataW-1:0]     PassBits    = FullMask[DataW-1:0];

    stage_state_e     state_q, state_d;
    logic [DataW-1:0] main_q, main_d;
    logic [DataW-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic deliver;

    // Both handshake outputs come straight from the state register, so there
    // is no combinational path from out_ready to in_ready.
    assign out_valid  = (state_q != StEmpty);
    assign in_ready   = (state_q != StSkid);
    assign out_data   = main_q;
    assign bubble_cnt = cnt_q;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (flush) begin
            // Any handshake in this cycle is treated as done and its data dropped.
            state_d = StEmpty;
            main_d  = in_data & PassBits;
            cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (accept && deliver) begin
                        main_d = in_data;
                    end else if (deliver) begin
                        state_d = StEmpty;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = StSkid;
                    end
                end
                StSkid: begin
                    if (deliver) begin
                        main_d  = skid_q;
                        state_d = StFull;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg plus hand-written sequences
// for asynchronous reset and bubble counter saturation.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [7:0]        bubble_cnt;

    logic              in_ready2;
    logic              out_valid2;
    logic [DATA_W-1:0] out_data2;
    logic [1:0]        bubble_cnt2;

    int checks;
    int errors;

    pipe_stage_reg #(
        .WIDTH      (32),
        .NUM_FIELDS (4),
        .PASS_MASK  (4'b0001),
        .CNT_W      (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .bubble_cnt (bubble_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipe_stage_reg #(
        .WIDTH      (32),
        .NUM_FIELDS (4),
        .PASS_MASK  (4'b0001),
        .CNT_W      (2)
    ) u_dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .flush      (flush),
        .bubble_cnt (bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic              ordy;
        logic              fl;
        logic [DATA_W-1:0] din;
        logic              exp_ov;
        logic              exp_ir;
        logic [DATA_W-1:0] exp_dout;
        logic [7:0]        exp_cnt;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [DATA_W-1:0] din);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = din;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [DATA_W-1:0] din, input logic ov,
                                input logic ir, input logic [DATA_W-1:0] dout,
                                input logic [7:0] cnt);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = din;
        v.exp_ov = ov; v.exp_ir = ir; v.exp_dout = dout; v.exp_cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [DATA_W-1:0] flush_word;
        logic [DATA_W-1:0] skid_flush_word;
        checks = 0;
        errors = 0;

        flush_word      = {32'h0000DEAD, 32'h0000BEEF, 32'h00001234, 32'h00000400};
        skid_flush_word = {32'h99, 32'h88, 32'h66, 32'h55};

        // Streaming: one item per cycle, visible right after the accepting edge.
        vecs[0]  = mk(1, 1, 0, 128'h1,   1, 1, 128'h1,   8'd0);
        vecs[1]  = mk(1, 1, 0, 128'h2,   1, 1, 128'h2,   8'd0);
        vecs[2]  = mk(1, 1, 0, 128'h3,   1, 1, 128'h3,   8'd0);
        vecs[3]  = mk(1, 1, 0, 128'h4,   1, 1, 128'h4,   8'd0);
        vecs[4]  = mk(0, 1, 0, 128'h0,   0, 1, 128'h4,   8'd0);
        // Backpressure: A into main, B into skid, C refused, then drain A, B.
        vecs[5]  = mk(1, 0, 0, 128'hA,   1, 1, 128'hA,   8'd0);
        vecs[6]  = mk(1, 0, 0, 128'hB,   1, 0, 128'hA,   8'd0);
        vecs[7]  = mk(1, 0, 0, 128'hC,   1, 0, 128'hA,   8'd0);
        vecs[8]  = mk(0, 1, 0, 128'h0,   1, 1, 128'hB,   8'd0);
        vecs[9]  = mk(0, 1, 0, 128'h0,   0, 1, 128'hB,   8'd0);
        // Flush from EMPTY keeps field 0 only.
        vecs[10] = mk(1, 0, 1, flush_word, 0, 1, 128'h400, 8'd1);
        // Flush while in SKID drops both entries.
        vecs[11] = mk(1, 0, 0, 128'h11,  1, 1, 128'h11,  8'd1);
        vecs[12] = mk(1, 0, 0, 128'h22,  1, 0, 128'h11,  8'd1);
        vecs[13] = mk(1, 1, 1, skid_flush_word, 0, 1, 128'h55, 8'd2);
        vecs[14] = mk(0, 1, 0, 128'h0,   0, 1, 128'h55,  8'd2);
        vecs[15] = mk(0, 1, 0, 128'h0,   0, 1, 128'h55,  8'd2);
        // FULL with neither handshake holds its data.
        vecs[16] = mk(1, 0, 0, 128'h77,  1, 1, 128'h77,  8'd2);
        vecs[17] = mk(0, 0, 0, 128'h0,   1, 1, 128'h77,  8'd2);
        vecs[18] = mk(0, 1, 0, 128'h0,   0, 1, 128'h77,  8'd2);

        rst = 1'b1;
        drive(0, 0, 0, '0);
        #12;
        rst = 1'b0;
        #1;
        check("reset_out_valid", {127'b0, out_valid}, 128'h0);
        check("reset_in_ready", {127'b0, in_ready}, 128'h1);
        check("reset_out_data", out_data, 128'h0);
        check("reset_bubble_cnt", {120'b0, bubble_cnt}, 128'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].din);
            step();
            check($sformatf("vec%0d_out_valid", i), {127'b0, out_valid}, {127'b0, vecs[i].exp_ov});
            check($sformatf("vec%0d_in_ready", i), {127'b0, in_ready}, {127'b0, vecs[i].exp_ir});
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_dout);
            check($sformatf("vec%0d_bubble_cnt", i), {120'b0, bubble_cnt}, {120'b0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_sat_cnt", i), {126'b0, bubble_cnt2},
                  {126'b0, vecs[i].exp_cnt[1:0]});
        end

        // Asynchronous reset mid-stream with both entries occupied.
        drive(1, 0, 0, 128'hAA);
        step();
        drive(1, 0, 0, 128'hBB);
        step();
        check("pre_reset_in_ready", {127'b0, in_ready}, 128'h0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {127'b0, out_valid}, 128'h0);
        check("async_rst_in_ready", {127'b0, in_ready}, 128'h1);
        check("async_rst_out_data", out_data, 128'h0);
        check("async_rst_bubble_cnt", {120'b0, bubble_cnt}, 128'h0);
        #2;
        rst = 1'b0;
        drive(0, 1, 0, '0);
        step();
        check("post_rst_no_item", {127'b0, out_valid}, 128'h0);
        check("post_rst_data", out_data, 128'h0);

        // Counter saturation: flush with in_valid low still passes field 0.
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, {32'hFF, 32'hEE, 32'hDD, 32'(i)});
            step();
            check($sformatf("sat%0d_cnt8", i), {120'b0, bubble_cnt}, 128'(i));
            check($sformatf("sat%0d_cnt2", i), {126'b0, bubble_cnt2}, (i >= 3) ? 128'd3 : 128'(i));
            check($sformatf("sat%0d_data", i), out_data, 128'(i));
            check($sformatf("sat%0d_out_valid", i), {127'b0, out_valid2}, 128'h0);
        end
        drive(0, 1, 0, '0);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("sat_hold%0d_cnt2", i), {126'b0, bubble_cnt2}, 128'd3);
            check($sformatf("sat_hold%0d_cnt8", i), {120'b0, bubble_cnt}, 128'd5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
